// File: rtl/dot_product_arbiter.sv
// dot_product_arbiter: round-robin scheduler sharing one dot_product engine between N_REQ
// requesters. A granted vector pair is latched, the engine is pulsed through reset and
// compute, and the 32-bit result is returned to the owner over a shared response bus.
// A watchdog turns a hung engine into an error response carrying a quiet NaN.
//
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   req_valid/req_ready   - per-requester operand handshake (ready is combinational)
//   req_vec1/req_vec2     - per-requester operand vectors
//   resp_valid/resp_ready - per-requester response handshake (at most one valid bit)
//   resp_result           - shared 32-bit result bus
//   resp_error            - marks resp_result as a watchdog abort
//   eng_rst               - engine reset, low only while the engine computes
//   eng_vec1/eng_vec2     - latched operands driven to the engine
//   eng_done/eng_result   - engine completion flag and result
module dot_product_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned VECTOR_LEN = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec1,
  input  logic [N_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec2,
  output logic [N_REQ-1:0]                       resp_valid,
  input  logic [N_REQ-1:0]                       resp_ready,
  output logic [31:0]                            resp_result,
  output logic                                   resp_error,
  output logic                                   eng_rst,
  output logic [VECTOR_LEN-1:0][31:0]            eng_vec1,
  output logic [VECTOR_LEN-1:0][31:0]            eng_vec2,
  input  logic                                   eng_done,
  input  logic [31:0]                            eng_result
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] QNaN = 32'h7FC00000;

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StResp} state_e;

  state_e                      state_q;
  logic [IdxW-1:0]             ptr_q;
  logic [IdxW-1:0]             owner_q;
  logic [WdW-1:0]              wd_q;
  logic [31:0]                 resp_result_q;
  logic                        resp_error_q;
  logic [VECTOR_LEN-1:0][31:0] eng_vec1_q;
  logic [VECTOR_LEN-1:0][31:0] eng_vec2_q;

  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !rst && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign eng_rst     = (state_q != StBusy);
  assign eng_vec1    = eng_vec1_q;
  assign eng_vec2    = eng_vec2_q;
  assign resp_result = resp_result_q;
  assign resp_error  = resp_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= IdxW'(N_REQ - 1);
      owner_q       <= '0;
      wd_q          <= '0;
      resp_result_q <= '0;
      resp_error_q  <= 1'b0;
      eng_vec1_q    <= '0;
      eng_vec2_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // grant_found here implies the granted requester sees req_ready high.
          if (grant_found) begin
            eng_vec1_q <= req_vec1[grant_idx];
            eng_vec2_q <= req_vec2[grant_idx];
            owner_q    <= grant_idx;
            ptr_q      <= grant_idx;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          // eng_done is ignored here: a stale flag must never be captured.
          wd_q    <= '0;
          state_q <= StBusy;
        end
        StBusy: begin
          wd_q <= wd_q + 1'b1;
          if (eng_done) begin
            resp_result_q <= eng_result;
            resp_error_q  <= 1'b0;
            state_q       <= StResp;
          end else if (TIMEOUT != 0 && 32'(wd_q) == TIMEOUT - 1) begin
            resp_result_q <= QNaN;
            resp_error_q  <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
